// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit for the execute stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on operand magnitudes; signs are re-applied in the final step.
// Divide-by-zero and signed overflow finish one cycle after accept.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ONES_C    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_C    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_C     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(XLEN - 1);

  // Two's complement negation of one word.
  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             a_neg_q, b_neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  opnd_q;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]  hi_q;     // product high half / partial remainder
  logic [XLEN-1:0]  lo_q;     // multiplier / dividend-becoming-quotient
  logic             busy_q, done_q;
  logic [XLEN-1:0]  result_q;
  logic [4:0]       rd_out_q;

  logic             a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]  a_mag_s, b_mag_s;
  logic             special_s;
  logic [XLEN-1:0]  special_res_s;

  // Decode operand signedness, magnitudes and the early-exit cases at accept.
  always_comb begin
    a_signed_s = (funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6);
    b_signed_s = (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
    a_neg_s    = a_signed_s & rs1_data[XLEN-1];
    b_neg_s    = b_signed_s & rs2_data[XLEN-1];
    if (a_neg_s) begin
      a_mag_s = neg_f(rs1_data);
    end else begin
      a_mag_s = rs1_data;
    end
    if (b_neg_s) begin
      b_mag_s = neg_f(rs2_data);
    end else begin
      b_mag_s = rs2_data;
    end
    special_s     = 1'b0;
    special_res_s = ZERO_C;
    if (funct3[2] && (rs2_data == ZERO_C)) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? rs1_data : ONES_C;
    end else if (funct3[2] && !funct3[0] && (rs1_data == MIN_C) && (rs2_data == ONES_C)) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? ZERO_C : rs1_data;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO_C;
    end
  end

  logic [XLEN:0]   mul_sum_s, div_t_s, div_diff_s;
  logic [XLEN-1:0] hi_nxt_s, lo_nxt_s, fin_res_s, prod_hi_neg_s;

  // One iteration step plus sign fix-up of the value it would produce.
  always_comb begin
    mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    div_t_s    = {hi_q, lo_q[XLEN-1]};
    div_diff_s = div_t_s - {1'b0, opnd_q};
    if (!op_q[2]) begin
      hi_nxt_s = mul_sum_s[XLEN:1];
      lo_nxt_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
    end else if (!div_diff_s[XLEN]) begin
      hi_nxt_s = div_diff_s[XLEN-1:0];
      lo_nxt_s = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_nxt_s = div_t_s[XLEN-1:0];
      lo_nxt_s = {lo_q[XLEN-2:0], 1'b0};
    end
    // High half of the 2*XLEN-bit negation: borrow only propagates if low half is zero.
    prod_hi_neg_s = ~hi_nxt_s + ((lo_nxt_s == ZERO_C) ? {{(XLEN-1){1'b0}}, 1'b1} : ZERO_C);
    case (op_q)
      3'd0:    fin_res_s = lo_nxt_s;
      3'd1,
      3'd2:    fin_res_s = (a_neg_q ^ b_neg_q) ? prod_hi_neg_s : hi_nxt_s;
      3'd3:    fin_res_s = hi_nxt_s;
      3'd4:    fin_res_s = (a_neg_q ^ b_neg_q) ? neg_f(lo_nxt_s) : lo_nxt_s;
      3'd5:    fin_res_s = lo_nxt_s;
      3'd6:    fin_res_s = a_neg_q ? neg_f(hi_nxt_s) : hi_nxt_s;
      3'd7:    fin_res_s = hi_nxt_s;
      default: fin_res_s = ZERO_C;
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      opnd_q   <= ZERO_C;
      hi_q     <= ZERO_C;
      lo_q     <= ZERO_C;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= ZERO_C;
      rd_out_q <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= funct3;
            rd_q    <= rd_in;
            a_neg_q <= a_neg_s;
            b_neg_q <= b_neg_s;
            cnt_q   <= {CNT_W{1'b0}};
            hi_q    <= ZERO_C;
            opnd_q  <= funct3[2] ? b_mag_s : a_mag_s;
            lo_q    <= funct3[2] ? a_mag_s : b_mag_s;
            busy_q  <= 1'b1;
            if (special_s) begin
              result_q <= special_res_s;
              rd_out_q <= rd_in;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          hi_q  <= hi_nxt_s;
          lo_q  <= lo_nxt_s;
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_C) begin
            result_q <= fin_res_s;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: scoreboard of expected results, one task per scenario.
module tb_muldiv_unit;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] rs1_data = 64'd0;
  logic [63:0] rs2_data = 64'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done;
  logic [63:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.XLEN(64), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] obs_res;
  logic [4:0]  obs_rd;
  int          obs_lat;
  int          busy_cnt;
  logic        obs_done;

  // Independent reference using wide arithmetic.
  function automatic logic [63:0] ref_f(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sbx, ua, ub, p;
    logic signed [63:0] a_s, b_s, q_s;
    sa = {{64{a[63]}}, a};
    sbx = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    a_s = a;
    b_s = b;
    p = 128'd0;
    case (f3)
      3'd0: begin p = ua * ub; return p[63:0]; end
      3'd1: begin p = sa * sbx; return p[127:64]; end
      3'd2: begin p = sa * ub; return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: begin
        if (b == 64'd0) return ONES;
        if (a == MINV && b == ONES) return a;
        q_s = a_s / b_s;
        return q_s;
      end
      3'd5: return (b == 64'd0) ? ONES : a / b;
      3'd6: begin
        if (b == 64'd0) return a;
        if (a == MINV && b == ONES) return 64'd0;
        q_s = a_s % b_s;
        return q_s;
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    if (f3[2] && (b == 64'd0)) return 0;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == MINV && b == ONES) return 0;
    return 64;
  endfunction

  // Drive one operation, push its expectation, scramble inputs after accept, wait for done.
  task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] expv);
    exp_t x;
    x.res = expv;
    x.rd = rd;
    x.lat = exp_lat(f3, a, b);
    sbq.push_back(x);
    @(negedge clk);
    funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    rs1_data = {$urandom, $urandom};
    rs2_data = {$urandom, $urandom};
    rd_in = 5'($urandom_range(0, 31));
    obs_lat = 0;
    busy_cnt = 0;
    while (!done && obs_lat < 200) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      obs_lat++;
    end
    if (busy) busy_cnt++;
    obs_done = done;
    obs_res = result;
    obs_rd = rd_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, result, rd_out} !== 71'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b result=%h rd_out=%0d, required all zero", busy, done, result, rd_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ops();
    logic [2:0]  f3s [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd7};
    logic [63:0] as  [14] = '{64'd7, MINV, ONES, ONES, -64'sd7, -64'sd7, 64'd100, 64'd100,
                              64'd123, 64'd5, MINV, MINV, 64'd0, 64'd9};
    logic [63:0] bs  [14] = '{-64'sd3, MINV, ONES, 64'd2, 64'd2, 64'd2, 64'd7, 64'd7,
                              64'd0, 64'd0, ONES, ONES, 64'd12345, 64'd0};
    logic [63:0] xs  [14] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000,
                              64'hFFFF_FFFF_FFFF_FFFE, ONES, 64'hFFFF_FFFF_FFFF_FFFD, ONES,
                              64'd14, 64'd2, ONES, 64'd5, MINV, 64'd0, 64'd0, 64'd9};
    for (int i = 0; i < 14; i++) begin
      issue(f3s[i], as[i], bs[i], 5'(i + 5), xs[i]);
      e = sbq.pop_front();
      tests_run++;
      if (!obs_done || obs_res !== e.res || obs_rd !== e.rd) begin
        tests_failed++;
        $display("FAIL op%0d_f%0d: done=%b result=%h rd=%0d, required result=%h rd=%0d",
                 i, f3s[i], obs_done, obs_res, obs_rd, e.res, e.rd);
      end
      tests_run++;
      if (obs_lat != e.lat || busy_cnt != e.lat + 1) begin
        tests_failed++;
        $display("FAIL op%0d_latency: latency=%0d busy_cycles=%0d, required %0d and %0d",
                 i, obs_lat, busy_cnt, e.lat, e.lat + 1);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== e.res || rd_out !== e.rd) begin
        tests_failed++;
        $display("FAIL op%0d_after_done: done=%b busy=%b result=%h rd=%0d, required 0 0 %h %0d",
                 i, done, busy, result, rd_out, e.res, e.rd);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [63:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 5 == 1) b = b >> $urandom_range(1, 63);
      if (i % 9 == 2) b = 64'd0;
      if (i % 11 == 3) begin a = MINV; b = ONES; end
      if (i % 7 == 4) a = -a;
      issue(f3, a, b, 5'(i), ref_f(f3, a, b));
      e = sbq.pop_front();
      tests_run++;
      if (!obs_done || obs_res !== e.res || obs_rd !== e.rd || obs_lat != e.lat) begin
        tests_failed++;
        $display("FAIL rand%0d_f%0d a=%h b=%h: result=%h rd=%0d lat=%0d, required %h %0d %0d",
                 i, f3, a, b, obs_res, obs_rd, obs_lat, e.res, e.rd, e.lat);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n_done = 0;
    int lat = -1;
    logic [63:0] first_res = 64'd0;
    e.res = 64'hFFFF_FFFF_FFFF_FFEB; e.rd = 5'd9; e.lat = 64;
    sbq.push_back(e);
    @(negedge clk);
    funct3 = 3'd0; rs1_data = 64'd7; rs2_data = -64'sd3; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 120; k++) begin
      if (k == 10) begin
        funct3 = 3'd5; rs1_data = 64'd100; rs2_data = 64'd0; rd_in = 5'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        if (lat < 0) begin lat = k; first_res = result; end
      end
      @(negedge clk);
    end
    e = sbq.pop_front();
    tests_run++;
    if (n_done != 1 || lat != e.lat || first_res !== e.res || rd_out !== e.rd) begin
      tests_failed++;
      $display("FAIL busy_ignore: pulses=%0d lat=%0d result=%h rd=%0d, required 1 %0d %h %0d",
               n_done, lat, first_res, rd_out, e.lat, e.res, e.rd);
    end
  endtask

  task automatic test_reset_abort();
    int n_done = 0;
    e.res = 64'd142; e.rd = 5'd7; e.lat = 64;
    sbq.push_back(e);
    @(negedge clk);
    funct3 = 3'd4; rs1_data = 64'd1000; rs2_data = 64'd7; rd_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sbq.pop_front());
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0 || rd_out !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_abort_state: busy=%b done=%b result=%h rd=%0d, required all zero",
               busy, done, result, rd_out);
    end
    for (int k = 0; k < 80; k++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    tests_run++;
    if (n_done != 0) begin
      tests_failed++;
      $display("FAIL reset_abort_no_done: pulses=%0d, required 0", n_done);
    end
    issue(3'd5, 64'd100, 64'd7, 5'd12, 64'd14);
    e = sbq.pop_front();
    tests_run++;
    if (!obs_done || obs_res !== e.res || obs_rd !== e.rd || obs_lat != e.lat) begin
      tests_failed++;
      $display("FAIL reset_abort_next_op: result=%h rd=%0d lat=%0d, required %h %0d %0d",
               obs_res, obs_rd, obs_lat, e.res, e.rd, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
